tt_um_islam_ihfaz_mux_arbiter: RTL and testbench

Two-requester arbiter that owns the select line of the shared 2:1 data mux on the Tiny Tapeout tile. It decides which of two requesters, A or B, drives the single output bit. Policy is either round-robin or fixed priority to A, with a minimum grant hold time and a starvation timeout. Grant state, hold counter and a grant-switch counter are exported on the spare outputs for observation.

---
 rtl/tt_um_islam_ihfaz_mux_arbiter.sv | 125 ++++++++++++
 tb/tb_tt_um_islam_ihfaz_mux_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_islam_ihfaz_mux_arbiter.sv
// Two-requester arbiter driving the select of the tile's shared 2:1 data mux.
// Round-robin or priority-A policy with minimum hold time and starvation timeout.
module tt_um_islam_ihfaz_mux_arbiter #(
  parameter int HOLD_MIN = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [3:0] HELD_TH = 4'(HOLD_MIN - 1);
  localparam logic [3:0] EXP_TH  = 4'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       gnt_a;
  logic       gnt_b;
  logic       last;
  logic [3:0] hold_cnt;
  logic [7:0] switch_cnt;

  logic req_a;
  logic req_b;
  logic data_a;
  logic data_b;
  logic mode;
  logic held;
  logic expired;
  logic unused_ok;

  assign req_a  = ui_in[0];
  assign req_b  = ui_in[1];
  assign data_a = ui_in[2];
  assign data_b = ui_in[3];
  assign mode   = ui_in[4];

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

  assign held    = (hold_cnt >= HELD_TH);
  assign expired = (hold_cnt >= EXP_TH);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_a && req_b) begin
          // A tie goes to A in priority mode, otherwise away from the last winner.
          state_nxt = (mode || last) ? GRANT_A : GRANT_B;
        end else if (req_a) begin
          state_nxt = GRANT_A;
        end else if (req_b) begin
          state_nxt = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!mode && req_b && expired) begin
          state_nxt = GRANT_B;
        end else if (!req_a && held) begin
          state_nxt = req_b ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (mode && req_a && held) begin
          state_nxt = GRANT_A;
        end else if (!mode && req_a && expired) begin
          state_nxt = GRANT_A;
        end else if (!req_b && held) begin
          state_nxt = req_a ? GRANT_A : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      last       <= 1'b1;
      hold_cnt   <= '0;
      switch_cnt <= '0;
    end else begin
      state <= state_nxt;
      gnt_a <= (state_nxt == GRANT_A);
      gnt_b <= (state_nxt == GRANT_B);
      if (state_nxt != IDLE && state_nxt != state) begin
        hold_cnt   <= '0;
        last       <= (state_nxt == GRANT_B);
        switch_cnt <= switch_cnt + 8'd1;
      end else if (state_nxt != IDLE) begin
        if (hold_cnt != 4'hF) begin
          hold_cnt <= hold_cnt + 4'd1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  always_comb begin
    uo_out    = '0;
    uo_out[0] = (gnt_a & data_a) | (gnt_b & data_b);
    uo_out[1] = gnt_a;
    uo_out[2] = gnt_b;
    uo_out[3] = last;
    uo_out[7:4] = hold_cnt;
  end

  assign uio_out = switch_cnt;
  assign uio_oe  = '1;

endmodule

// File: tb/tb_tt_um_islam_ihfaz_mux_arbiter.sv
// Randomized bench for the mux arbiter against a grant/owner reference model.
`timescale 1ns/1ps
module tb_tt_um_islam_ihfaz_mux_arbiter;

  localparam int HOLD_MIN = 2;
  localparam int TIMEOUT  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int m_owner = 0;
  int m_hold  = 0;
  int m_last  = 1;
  int m_sw    = 0;

  tt_um_islam_ihfaz_mux_arbiter #(
    .HOLD_MIN(HOLD_MIN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input int ra, input int rb, input int md, input int rst);
    int nxt;
    bit held;
    bit expired;
    int mine;
    int other;
    if (rst == 0) begin
      m_owner = 0; m_hold = 0; m_last = 1; m_sw = 0;
      return;
    end
    held    = (m_hold >= HOLD_MIN - 1);
    expired = (m_hold >= TIMEOUT - 1);
    if (m_owner == 0) begin
      if (ra != 0 && rb != 0) nxt = (md != 0) ? 1 : (m_last != 0 ? 1 : 2);
      else if (ra != 0)       nxt = 1;
      else if (rb != 0)       nxt = 2;
      else                    nxt = 0;
    end else begin
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (md != 0 && m_owner == 2 && ra != 0 && held) nxt = 1;
      else if (md == 0 && other != 0 && expired)      nxt = 3 - m_owner;
      else if (mine == 0 && held)                     nxt = (other != 0) ? 3 - m_owner : 0;
      else                                            nxt = m_owner;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_hold = 0;
      m_last = (nxt == 2) ? 1 : 0;
      m_sw   = (m_sw + 1) % 256;
    end else if (nxt != 0) begin
      m_hold = (m_hold < 15) ? m_hold + 1 : 15;
    end else begin
      m_hold = 0;
    end
    m_owner = nxt;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare just after.
  task automatic step(input int ra, input int rb, input int md, input int rst);
    int da;
    int db;
    int exp_mux;
    da = $urandom_range(0, 1);
    db = $urandom_range(0, 1);
    ui_in = {3'($urandom_range(0, 7)), 1'(md), 1'(db), 1'(da), 1'(rb), 1'(ra)};
    uio_in = 8'($urandom);
    rst_n = 1'(rst);
    @(posedge clk);
    model_update(ra, rb, md, rst);
    #1;
    exp_mux = (m_owner == 1) ? da : (m_owner == 2) ? db : 0;
    check("mux_out", int'(uo_out[0]), exp_mux);
    check("gnt_a", int'(uo_out[1]), (m_owner == 1) ? 1 : 0);
    check("gnt_b", int'(uo_out[2]), (m_owner == 2) ? 1 : 0);
    check("last", int'(uo_out[3]), m_last);
    check("hold_cnt", int'(uo_out[7:4]), m_hold);
    check("switch_cnt", int'(uio_out), m_sw);
    check("uio_oe", int'(uio_oe), 255);
    check("gnt_exclusive", int'(uo_out[1] & uo_out[2]), 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    int guard;

    // Reset state
    do_reset();
    check("rst_uo_out", int'(uo_out), 8'h08);
    check("rst_switch_cnt", int'(uio_out), 0);

    // Single-cycle request still holds HOLD_MIN cycles
    step(1, 0, 0, 1);
    check("short_req_gnt_a_1", int'(uo_out[1]), 1);
    step(0, 0, 0, 1);
    check("short_req_gnt_a_2", int'(uo_out[1]), 1);
    step(0, 0, 0, 1);
    check("short_req_idle", int'(uo_out[2:0]), 0);
    check("short_req_switch_cnt", int'(uio_out), 1);

    // Round-robin with both requesting: alternating TIMEOUT-cycle grants
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 1, 0, 1);
    check("rr_switch_cnt", int'(uio_out), 5);

    // Priority mode, both requesting: A keeps it, hold_cnt saturates
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 1, 1, 1);
    check("prio_hold_sat", int'(uo_out[7:4]), 15);
    check("prio_switch_cnt", int'(uio_out), 1);

    // Priority mode preemption of B once B has held
    do_reset();
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    check("preempt_still_b", int'(uo_out[2]), 1);
    step(1, 1, 1, 1);
    check("preempt_gnt_a", int'(uo_out[1]), 1);
    check("preempt_last", int'(uo_out[3]), 0);
    check("preempt_switch_cnt", int'(uio_out), 2);

    // 256 single-cycle requests alternating A/B: switch_cnt wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) step(1, 0, 0, 1);
      else            step(0, 1, 0, 1);
      for (int g = 0; g < 3; g++) step(0, 0, int'($urandom_range(0, 1)), 1);
    end
    check("wrap_switch_cnt", int'(uio_out), 0);

    // Mid-grant reset at hold_cnt=5
    do_reset();
    guard = 0;
    step(1, 0, 1, 1);
    while (m_hold != 5 && guard < 20) begin
      step(1, 0, 1, 1);
      guard++;
    end
    check("midrst_reached_hold5", int'(uo_out[7:4]), 5);
    step(1, 1, 1, 0);
    check("midrst_uo_out", int'(uo_out), 8'h08);
    check("midrst_switch_cnt", int'(uio_out), 0);
    step(1, 1, 0, 1);
    check("midrst_restart_gnt_a", int'(uo_out[1]), 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      int ra;
      int rb;
      ra = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rb = ($urandom_range(0, 3) != 0) ? 1 : 0;
      step(ra, rb, int'($urandom_range(0, 1)),
           ($urandom_range(0, 199) == 0) ? 0 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
